// File: rtl/fifo_pkg.sv
// Shared types for the small first-word-fall-through FIFO.
package fifo_pkg;

  // Per-cycle classification of accepted requests; drives the occupancy update.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo.sv
// Single-clock FIFO with first-word-fall-through read port and
// full / almost_full / empty flags decoded from a registered occupancy count.
module fifo
  import fifo_pkg::*;
#(
  parameter int NUM_SLOTS     = 4,
  parameter int LOG_NUM_SLOTS = 2,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_write,
  input  logic                  write,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] data_read,
  input  logic                  next_read,
  output logic                  empty
);

  logic [LOG_NUM_SLOTS-1:0] wr_ptr;
  logic [LOG_NUM_SLOTS-1:0] rd_ptr;
  logic [LOG_NUM_SLOTS:0]   count;
  logic [DATA_WIDTH-1:0]    mem [NUM_SLOTS];

  logic     push;
  logic     pop;
  fifo_op_e op;

  // Flags depend only on registered state, never on this cycle's requests.
  assign empty       = (count == '0);
  assign full        = (count == (LOG_NUM_SLOTS+1)'(NUM_SLOTS));
  assign almost_full = (count >= (LOG_NUM_SLOTS+1)'(NUM_SLOTS - 1));

  assign push = write && !full;
  assign pop  = next_read && !empty;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    op = OP_NONE;
    if (push && pop)  op = OP_BOTH;
    else if (push)    op = OP_PUSH;
    else if (pop)     op = OP_POP;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LOG_NUM_SLOTS'(1);
      if (pop)  rd_ptr <= rd_ptr + LOG_NUM_SLOTS'(1);
      unique case (op)
        OP_PUSH: count <= count + (LOG_NUM_SLOTS+1)'(1);
        OP_POP:  count <= count - (LOG_NUM_SLOTS+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the empty flag masks stale entries and this keeps it RAM-mappable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_write;
  end

  assign data_read = mem[rd_ptr];

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fifo;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          clk;
  logic          rst;
  logic [DW-1:0] data_write;
  logic          write;
  logic          full;
  logic          almost_full;
  logic [DW-1:0] data_read;
  logic          next_read;
  logic          empty;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] model_q[$];

  fifo #(.NUM_SLOTS(DEPTH), .LOG_NUM_SLOTS(2), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_write (data_write),
    .write      (write),
    .full       (full),
    .almost_full(almost_full),
    .data_read  (data_read),
    .next_read  (next_read),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Compare flags and head against the reference queue.
  task automatic check_state(input string tag);
    check({tag, ".empty"},       DW'(empty),       DW'(model_q.size() == 0));
    check({tag, ".full"},        DW'(full),        DW'(model_q.size() == DEPTH));
    check({tag, ".almost_full"}, DW'(almost_full), DW'(model_q.size() >= DEPTH - 1));
    if (model_q.size() != 0) check({tag, ".head"}, data_read, model_q[0]);
  endtask

  // One clock cycle of requests; model follows the occupancy rules before the edge.
  task automatic step(input string tag, input logic w, input logic [DW-1:0] d, input logic r);
    bit do_w;
    bit do_r;
    write      = w;
    data_write = d;
    next_read  = r;
    do_w = w && (model_q.size() < DEPTH);
    do_r = r && (model_q.size() > 0);
    @(posedge clk);
    #1;
    if (do_r) void'(model_q.pop_front());
    if (do_w) model_q.push_back(d);
    write     = 1'b0;
    next_read = 1'b0;
    check_state(tag);
  endtask

  initial begin
    int popped;
    rst        = 1'b1;
    write      = 1'b0;
    next_read  = 1'b0;
    data_write = '0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    rst = 1'b0;

    // Fill and drain order; fifth write dropped.
    step("fill1", 1'b1, 32'h11, 1'b0);
    step("fill2", 1'b1, 32'h22, 1'b0);
    check("fill2.af_low", DW'(almost_full), DW'(1'b0));
    step("fill3", 1'b1, 32'h33, 1'b0);
    check("fill3.af_high", DW'(almost_full), DW'(1'b1));
    check("fill3.full_low", DW'(full), DW'(1'b0));
    step("fill4", 1'b1, 32'h44, 1'b0);
    check("fill4.full_high", DW'(full), DW'(1'b1));
    step("drop5", 1'b1, 32'h55, 1'b0);
    check("drop5.head", data_read, 32'h11);
    step("drain1", 1'b0, '0, 1'b1);
    step("drain2", 1'b0, '0, 1'b1);
    step("drain3", 1'b0, '0, 1'b1);
    check("drain3.head", data_read, 32'h44);
    step("drain4", 1'b0, '0, 1'b1);
    check("drain4.empty", DW'(empty), DW'(1'b1));

    // Fall-through latency.
    step("ft", 1'b1, 32'hA5, 1'b0);
    check("ft.data", data_read, 32'hA5);
    check("ft.empty", DW'(empty), DW'(1'b0));

    // Simultaneous read+write at occupancy 2.
    step("occ2", 1'b1, 32'hB6, 1'b0);
    step("rw2a", 1'b1, 32'hC7, 1'b1);
    check("rw2a.head", data_read, 32'hB6);
    step("rw2b", 1'b1, 32'hD8, 1'b1);
    step("rw_drain1", 1'b0, '0, 1'b1);
    step("rw_drain2", 1'b0, '0, 1'b1);

    // Streaming 20 values across pointer wrap; one in flight each cycle.
    popped = 0;
    step("stream0", 1'b1, 32'h100, 1'b0);
    for (int i = 1; i < 20; i++) begin
      check("stream.head", data_read, 32'h100 + DW'(i - 1));
      step("stream", 1'b1, 32'h100 + DW'(i), 1'b1);
      popped++;
    end
    check("stream.last", data_read, 32'h113);
    step("stream_end", 1'b0, '0, 1'b1);
    popped++;
    check("stream.count", DW'(popped), DW'(20));

    // Empty with both requests: write wins, read ignored.
    step("empty_both", 1'b1, 32'h7, 1'b1);
    check("empty_both.data", data_read, 32'h7);
    check("empty_both.empty", DW'(empty), DW'(1'b0));
    step("eb_drain", 1'b0, '0, 1'b1);

    // Full with both requests: read wins, write dropped.
    for (int i = 0; i < DEPTH; i++) step("fill_b", 1'b1, 32'h60 + DW'(i), 1'b0);
    step("full_both", 1'b1, 32'h66, 1'b1);
    check("full_both.full", DW'(full), DW'(1'b0));
    check("full_both.af", DW'(almost_full), DW'(1'b1));
    check("full_both.head", data_read, 32'h61);
    for (int i = 0; i < DEPTH - 1; i++) step("fb_drain", 1'b0, '0, 1'b1);
    check("fb_drain.empty", DW'(empty), DW'(1'b1));

    // Reads while empty, then a write becomes head.
    for (int i = 0; i < 3; i++) step("empty_rd", 1'b0, '0, 1'b1);
    step("after_empty", 1'b1, 32'h9, 1'b0);
    check("after_empty.head", data_read, 32'h9);
    step("ae_drain", 1'b0, '0, 1'b1);

    // Asynchronous reset mid-operation with two entries held.
    step("pre_rst1", 1'b1, 32'hE1, 1'b0);
    step("pre_rst2", 1'b1, 32'hE2, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_q.delete();
    check_state("async_rst");
    #1;
    rst = 1'b0;
    step("post_rst_rd", 1'b0, '0, 1'b1);
    check("post_rst_rd.empty", DW'(empty), DW'(1'b1));

    // Random traffic against the reference queue.
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 99) < 55), $urandom, 1'($urandom_range(0, 99) < 45));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
